// File: rtl/capture_reader_of_verifla.sv
// Capture-buffer reader: walks the circular capture memory once from a start
// address and streams each word MSB byte first over a valid/ready byte port.
module capture_reader_of_verifla #(
   parameter int LA_MEM_ADDRESS_BITS = 8,
   parameter int LA_MEM_WORDLEN_BITS = 24
) (
   input  logic                           clk,
   input  logic                           rst_l,
   input  logic                           start,
   input  logic [LA_MEM_ADDRESS_BITS-1:0] start_addr,
   output logic [LA_MEM_ADDRESS_BITS-1:0] addrb,
   input  logic [LA_MEM_WORDLEN_BITS-1:0] doutb,
   output logic [7:0]                     tx_data,
   output logic                           tx_valid,
   input  logic                           tx_ready,
   output logic                           busy,
   output logic                           done
);

   localparam int A              = LA_MEM_ADDRESS_BITS;
   localparam int W              = LA_MEM_WORDLEN_BITS;
   localparam int BYTES_PER_WORD = W / 8;
   localparam int BCW            = $clog2(BYTES_PER_WORD + 1);

   localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER_WORD - 1);
   localparam logic [A-1:0]   LAST_WORD = '1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SEND,
      FIN
   } state_t;

   state_t         r_state;
   state_t         w_nextState;
   logic [A-1:0]   r_addr;
   logic [A-1:0]   r_wordCnt;
   logic [BCW-1:0] r_byteCnt;
   logic [W-1:0]   r_shreg;
   logic [7:0]     r_txData;
   logic           r_txValid;
   logic           w_accept;
   logic           w_lastByte;
   logic           w_lastWord;
   logic [W-1:0]   w_shifted;

   assign w_accept   = r_txValid & tx_ready;
   assign w_lastByte = (r_byteCnt == LAST_BYTE);
   assign w_lastWord = (r_wordCnt == LAST_WORD);
   assign w_shifted  = r_shreg << 8;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (start) w_nextState = FETCH;
         FETCH:   w_nextState = LOAD;
         LOAD:    w_nextState = SEND;
         SEND:    if (w_accept && w_lastByte) w_nextState = w_lastWord ? FIN : FETCH;
         FIN:     w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Memory data lands in LOAD; SEND then peels bytes off the top of the shift register.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_addr    <= '0;
         r_wordCnt <= '0;
         r_byteCnt <= '0;
         r_shreg   <= '0;
         r_txData  <= '0;
         r_txValid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_addr    <= start_addr;
                  r_wordCnt <= '0;
               end
            end
            LOAD: begin
               r_shreg   <= doutb;
               r_txData  <= doutb[W-1 -: 8];
               r_txValid <= 1'b1;
               r_byteCnt <= '0;
            end
            SEND: begin
               if (w_accept) begin
                  if (!w_lastByte) begin
                     r_shreg   <= w_shifted;
                     r_txData  <= w_shifted[W-1 -: 8];
                     r_byteCnt <= r_byteCnt + BCW'(1);
                  end else begin
                     r_txValid <= 1'b0;
                     if (!w_lastWord) begin
                        r_addr    <= r_addr + A'(1);
                        r_wordCnt <= r_wordCnt + A'(1);
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign addrb    = r_addr;
   assign tx_data  = r_txData;
   assign tx_valid = r_txValid;
   assign busy     = (r_state == FETCH) || (r_state == LOAD) || (r_state == SEND);
   assign done     = (r_state == FIN);

endmodule
